jtframe_prom_dwnld: RTL and testbench
=====================================

# jtframe_prom_dwnld

Download router between the ioctl ROM loader and the SDRAM/PROM programming paths of a JTFRAME core, with game-reset sequencing. It generalises the fixed two-PROM write-enable split to PROM_N parametrised PROM channels. It adds an acknowledged SDRAM write handshake with a one-entry holding buffer and overflow detection. It owns the game reset, releasing it only after download completes and ROM data is ready.

## Interface
Parameters:
- PROM_N, 2, number of PROM write-enable channels (1..8)
- PROM_START, 22'h0C_0000, first ioctl byte address of PROM area; lower addresses go to SDRAM
- PROM_AW, 14, address bits per PROM region; region k spans PROM_START + k·2^PROM_AW
- RST_HOLD, 16, consecutive quiet cycles required before rst_game releases (≥1)

Ports:
- clk  in  1  system clock (48 MHz)
- rst  in  1  reset; asynchronous and active-high
- downloading  in  1  ioctl download in progress
- ioctl_addr  in  22  byte address from loader
- ioctl_data  in  8  byte from loader
- ioctl_wr  in  1  one-cycle byte strobe
- prog_addr  out  22  SDRAM word address, or PROM byte offset (zero-extended)
- prog_data  out  8  byte to write
- prog_mask  out  2  active-low byte enable; 2'b10 = low byte, 2'b01 = high byte
- prog_we  out  1  SDRAM write request, held until acknowledged
- prog_ack  in  1  SDRAM controller accepted the write
- prom_we  out  PROM_N  one-hot, one-cycle PROM write strobe
- rom_ready  in  1  ROM cache reports valid data
- dwnld_busy  out  1  router still has work
- overflow  out  1  sticky: a byte was dropped
- rst_game  out  1  reset for game logic

## Operation
- Reset values: prog_addr 0, prog_data 0, prog_mask 2'b11, prog_we 0, prom_we 0, overflow 0, rst_game 1, FSM IDLE, holding register empty.
- Decode per byte:
  - addr < PROM_START → SDRAM: prog_addr = {1'b0, addr[21:1]}, prog_mask = addr[0] ? 2'b01 : 2'b10.
  - Otherwise idx = (addr − PROM_START) >> PROM_AW.
  - idx < PROM_N → PROM k = idx: prog_addr = offset[PROM_AW−1:0], prog_mask 2'b11.
  - idx ≥ PROM_N → byte silently discarded; not overflow.
- FSM states:
  - IDLE: a source is the holding entry if full, else ioctl_wr. SDRAM target → SDRAM_WR. PROM target → PROM_WR. Discarded target → stay in IDLE.
  - SDRAM_WR: prog_we = 1. On prog_ack = 1 → IDLE; prog_we low next cycle.
  - PROM_WR: prom_we[k] = 1 for exactly this cycle, then IDLE.
- Holding buffer:
  - ioctl_wr arriving while FSM is not IDLE is stored if the buffer is empty.
  - If the buffer is full, the byte is dropped and overflow is set until rst.
  - In IDLE with the buffer full, the holding entry launches first. A simultaneous ioctl_wr is stored into the slot being vacated, with no loss.
- dwnld_busy = downloading | (FSM ≠ IDLE) | holding full.
- Reset release:
  - A counter loads RST_HOLD whenever rst, !rom_ready or dwnld_busy is active; rst_game = 1 while loading.
  - With all three clear, the counter decrements each cycle. rst_game falls on the cycle the counter reaches 0 and stays low.
  - Any reassertion sets rst_game high on the next edge and reloads the counter.
- downloading falling mid-write: in-flight and held writes complete normally; dwnld_busy covers them.
- rst asserted mid-write: everything clears immediately (async); the pending write is lost and prog_we drops at once.

## Timing
- ioctl_wr in cycle N with FSM IDLE and buffer empty: outputs registered at N+1. prog_we or prom_we[k] is high from N+1.
- SDRAM write: prog_we spans N+1 … cycle A where prog_ack is sampled high; low at A+1. Minimum two-cycle gap between launches (IDLE in between).
- PROM write: prom_we[k] high during N+1 only; FSM IDLE at N+2.
- prog_ack while prog_we = 0 is ignored.
- Reset release: earliest rst_game fall is RST_HOLD cycles after the last of (dwnld_busy low, rom_ready high, rst low).

## Test plan
- Byte 8'h5A at addr 22'h00_0003, ack 3 cycles later → prog_addr 22'h1, mask 2'b01, prog_we high for 4 cycles; prom_we stays 0.
- Byte at 22'h0C_4010 (PROM_AW = 14) → prom_we = 2'b10 for one cycle, prog_addr 22'h0010, prog_we 0. Byte at 22'h0C_8000 → no strobes, overflow 0.
- Hold prog_ack low; issue 3 ioctl_wr → first launched, second held, third dropped, overflow = 1. Release ack → held byte launched 2 cycles after the ack.
- Buffer full, IDLE, and new ioctl_wr in the same cycle → held byte launched, new byte stored, overflow 0.
- downloading falls with rom_ready = 1 and FSM idle → rst_game falls after exactly 16 cycles. Drop rom_ready at count 5 → rst_game stays high and the count restarts.
- Assert rst during SDRAM_WR → prog_we, prom_we and overflow go 0 and rst_game goes 1 without waiting for a clk edge.

Source files
------------

// File: rtl/jtframe_prom_dwnld.sv
// jtframe_prom_dwnld: routes ioctl bytes to SDRAM or PROM channels and sequences the game reset
module jtframe_prom_dwnld #(
    parameter int          PROM_N     = 2,
    parameter logic [21:0] PROM_START = 22'h0C_0000,
    parameter int          PROM_AW    = 14,
    parameter int          RST_HOLD   = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [21:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [21:0]       prog_addr,
    output logic [7:0]        prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    input  logic              prog_ack,
    output logic [PROM_N-1:0] prom_we,
    input  logic              rom_ready,
    output logic              dwnld_busy,
    output logic              overflow,
    output logic              rst_game
);
    localparam int CW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {IDLE, SDRAM_WR, PROM_WR} state_t;

    state_t            state, state_nx;
    logic              hold_full;
    logic [21:0]       hold_addr;
    logic [7:0]        hold_data;
    logic              src_valid, is_sdram, is_prom, launch;
    logic [21:0]       src_addr, src_off, src_idx;
    logic [7:0]        src_data;
    logic [PROM_N-1:0] src_sel, prom_sel;
    logic [CW-1:0]     cnt;

    // Pick the byte to launch (held entry has priority) and decode its target
    always_comb begin
        src_sel   = '0;
        src_valid = hold_full | ioctl_wr;
        src_addr  = hold_full ? hold_addr : ioctl_addr;
        src_data  = hold_full ? hold_data : ioctl_data;
        src_off   = src_addr - PROM_START;
        src_idx   = src_off >> PROM_AW;
        is_sdram  = src_addr < PROM_START;
        is_prom   = !is_sdram && src_idx < 22'(PROM_N);
        for (int i = 0; i < PROM_N; i++) src_sel[i] = is_prom && src_idx == 22'(i);
        launch    = state == IDLE && src_valid && (is_sdram || is_prom);
    end

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    // Next state and write strobes
    always_comb begin
        state_nx   = state;
        prog_we    = state == SDRAM_WR;
        prom_we    = state == PROM_WR ? prom_sel : '0;
        dwnld_busy = downloading | (state != IDLE) | hold_full;
        case (state)
            IDLE:     state_nx = !launch ? IDLE : is_sdram ? SDRAM_WR : PROM_WR;
            SDRAM_WR: state_nx = prog_ack ? IDLE : SDRAM_WR;
            default:  state_nx = IDLE;
        endcase
    end

    // Output registers, one-entry holding buffer and sticky overflow
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prom_sel  <= '0;
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            overflow  <= 1'b0;
        end else begin
            if (launch) begin
                prog_addr <= is_sdram ? {1'b0, src_addr[21:1]} : 22'(src_off[PROM_AW-1:0]);
                prog_data <= src_data;
                prog_mask <= is_sdram ? (src_addr[0] ? 2'b01 : 2'b10) : 2'b11;
                prom_sel  <= src_sel;
            end
            if (state == IDLE) begin
                if (hold_full) begin
                    hold_full <= ioctl_wr;
                    hold_addr <= ioctl_addr;
                    hold_data <= ioctl_data;
                end
            end else if (ioctl_wr) begin
                if (hold_full) overflow <= 1'b1;
                else begin
                    hold_full <= 1'b1;
                    hold_addr <= ioctl_addr;
                    hold_data <= ioctl_data;
                end
            end
        end

    // Game reset: release after RST_HOLD quiet cycles with ROM data ready
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt      <= CW'(RST_HOLD);
            rst_game <= 1'b1;
        end else if (!rom_ready || dwnld_busy) begin
            cnt      <= CW'(RST_HOLD);
            rst_game <= 1'b1;
        end else if (cnt != '0) begin
            cnt      <= cnt - CW'(1);
            rst_game <= cnt != CW'(1);
        end
endmodule

// File: tb/tb_jtframe_prom_dwnld.sv
// tb_jtframe_prom_dwnld: directed and randomized checks of the download router against a transaction model
module tb_jtframe_prom_dwnld;
    localparam int START    = 'h0C0000;
    localparam int REG      = 16384;
    localparam int NPROM    = 2;
    localparam int RST_HOLD = 16;

    typedef struct {
        bit          p;
        logic [1:0]  we;
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } wr_t;

    logic        clk, rst, downloading, ioctl_wr, prog_we, prog_ack;
    logic        rom_ready, dwnld_busy, overflow, rst_game;
    logic [21:0] ioctl_addr, prog_addr;
    logic [7:0]  ioctl_data, prog_data;
    logic [1:0]  prog_mask, prom_we;

    int  n_chk = 0, n_err = 0;
    bit  auto_ack = 0;
    wr_t exp_q[$];

    jtframe_prom_dwnld dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack), .prom_we(prom_we),
        .rom_ready(rom_ready), .dwnld_busy(dwnld_busy), .overflow(overflow),
        .rst_game(rst_game)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1;
        tick;
        ioctl_wr   = 0;
    endtask

    // Reference: what a byte at this address must eventually produce
    function automatic void expect_byte(input logic [21:0] a, input logic [7:0] d);
        int ai, idx;
        ai = int'(a);
        if (ai < START)
            exp_q.push_back('{1'b0, 2'b00, 22'(ai / 2), d, (ai % 2) ? 2'b01 : 2'b10});
        else begin
            idx = (ai - START) / REG;
            if (idx < NPROM) exp_q.push_back('{1'b1, 2'(1 << idx), 22'((ai - START) % REG), d, 2'b11});
        end
    endfunction

    function automatic logic [21:0] rand_addr;
        int s;
        s = $urandom_range(0, 9);
        if (s < 5) return 22'($urandom_range(0, START - 1));
        if (s < 9) return 22'(START + $urandom_range(0, NPROM * REG - 1));
        return 22'(START + NPROM * REG + $urandom_range(0, 'h1000));
    endfunction

    // Random acknowledge, including stray acks while no write is pending
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_ack) prog_ack = prog_we ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
    end

    // Monitor: every accepted SDRAM write or PROM strobe must match the next expected byte
    initial forever begin
        wr_t e;
        @(negedge clk);
        if ((prog_we && prog_ack) || |prom_we) begin
            if (exp_q.size() == 0) chk("spurious_write", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("kind", 32'(|prom_we), 32'(e.p));
                chk("prom_we", prom_we, e.we);
                chk("addr", prog_addr, e.a);
                chk("data", prog_data, e.d);
                chk("mask", prog_mask, e.m);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [21:0] a;
        logic [7:0]  d;
        int          n, q;
        bit          blk;
        rst = 1; downloading = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_data = 0;
        prog_ack = 0; rom_ready = 1;
        repeat (2) tick;
        chk("rst_prog_addr", prog_addr, 0);
        chk("rst_prog_data", prog_data, 0);
        chk("rst_prog_mask", prog_mask, 2'b11);
        chk("rst_prog_we", prog_we, 0);
        chk("rst_prom_we", prom_we, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rst_game", rst_game, 1);
        chk("rst_busy", dwnld_busy, 0);
        rst = 0;
        downloading = 1;
        tick;

        // SDRAM byte, acked three cycles after launch
        expect_byte(22'h000003, 8'h5A);
        wr(22'h000003, 8'h5A);
        chk("t1_we", prog_we, 1);
        chk("t1_addr", prog_addr, 22'h1);
        chk("t1_mask", prog_mask, 2'b01);
        chk("t1_data", prog_data, 8'h5A);
        chk("t1_prom", prom_we, 0);
        tick; chk("t1_we2", prog_we, 1);
        tick; chk("t1_we3", prog_we, 1);
        tick; prog_ack = 1; chk("t1_we4", prog_we, 1);
        tick; prog_ack = 0; chk("t1_we_low", prog_we, 0);
        tick;

        // PROM channel 1, then an address beyond the last PROM
        expect_byte(22'h0C4010, 8'hC3);
        wr(22'h0C4010, 8'hC3);
        chk("t2_prom", prom_we, 2'b10);
        chk("t2_addr", prog_addr, 22'h0010);
        chk("t2_we", prog_we, 0);
        tick; chk("t2_prom_off", prom_we, 0);
        tick;
        wr(22'h0C8000, 8'h11);
        chk("t2_disc_prom", prom_we, 0);
        chk("t2_disc_we", prog_we, 0);
        tick;
        chk("t2_disc_ovf", overflow, 0);

        // Held byte launches while a new byte is stored in the same cycle
        expect_byte(22'h000100, 8'hA1);
        expect_byte(22'h000201, 8'hB2);
        expect_byte(22'h000302, 8'hC3);
        wr(22'h000100, 8'hA1);
        wr(22'h000201, 8'hB2);
        tick; prog_ack = 1;
        tick; prog_ack = 0;
        wr(22'h000302, 8'hC3);
        chk("t4_we", prog_we, 1);
        chk("t4_addr", prog_addr, 22'h100);
        chk("t4_mask", prog_mask, 2'b01);
        chk("t4_ovf", overflow, 0);
        prog_ack = 1;
        tick; prog_ack = 0;
        tick;
        chk("t4_we_c", prog_we, 1);
        chk("t4_addr_c", prog_addr, 22'h181);
        chk("t4_mask_c", prog_mask, 2'b10);
        prog_ack = 1;
        tick; prog_ack = 0;
        tick;
        chk("t4_ovf_end", overflow, 0);
        chk("t4_queue", exp_q.size(), 0);

        // Randomized pairs of bytes with random ack latency
        auto_ack = 1;
        for (int it = 0; it < 40; it++) begin
            a = rand_addr(); d = 8'($urandom);
            expect_byte(a, d);
            wr(a, d);
            repeat ($urandom_range(0, 2)) tick;
            a = rand_addr(); d = 8'($urandom);
            expect_byte(a, d);
            wr(a, d);
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                tick;
                n++;
            end
            chk("rand_drain", exp_q.size(), 0);
            exp_q.delete();
            repeat (2) tick;
        end
        auto_ack = 0;
        prog_ack = 0;
        tick;
        chk("rand_ovf", overflow, 0);

        // Overflow: third byte dropped while ack is held low
        expect_byte(22'h000010, 8'h01);
        expect_byte(22'h000011, 8'h02);
        wr(22'h000010, 8'h01);
        wr(22'h000011, 8'h02);
        wr(22'h000012, 8'h03);
        chk("t3_ovf", overflow, 1);
        chk("t3_we", prog_we, 1);
        tick;
        tick; prog_ack = 1;
        tick; prog_ack = 0;
        chk("t3_gap", prog_we, 0);
        tick;
        chk("t3_held_we", prog_we, 1);
        chk("t3_held_addr", prog_addr, 22'h008);
        chk("t3_held_mask", prog_mask, 2'b01);
        prog_ack = 1;
        tick; prog_ack = 0;
        repeat (2) tick;
        chk("t3_queue", exp_q.size(), 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Reset release: count quiet cycles, with rom_ready dropping once
        downloading = 0;
        q = 0;
        for (int j = 0; j < 30; j++) begin
            rom_ready = (j != 5);
            blk = !rom_ready;
            tick;
            q = blk ? 0 : q + 1;
            chk("rst_game_seq", rst_game, 32'(q < RST_HOLD));
        end
        chk("rg_low", rst_game, 0);
        #2 rst = 1;
        #1 chk("rg_async", rst_game, 1);
        tick;
        rst = 0;
        tick;

        // rst in the middle of an SDRAM write with overflow set
        downloading = 1;
        wr(22'h000020, 8'h44);
        wr(22'h000021, 8'h55);
        wr(22'h000022, 8'h66);
        chk("t6_we_pre", prog_we, 1);
        chk("t6_ovf_pre", overflow, 1);
        #2 rst = 1;
        #1;
        chk("t6_we", prog_we, 0);
        chk("t6_prom", prom_we, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_rst_game", rst_game, 1);
        chk("t6_mask", prog_mask, 2'b11);
        tick;
        rst = 0;
        downloading = 0;
        repeat (3) tick;
        chk("final_queue", exp_q.size(), 0);
        chk("final_we", prog_we, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
